// File: rtl/rr_arbiter_8_way.sv
// Round-robin arbiter: shares one single-owner resource between 8 requesters.
// Grants are one-hot and registered, and each grant is held until the owner
// releases, drops its request or reaches the hold limit. A single idle cycle
// always separates two grants so the downstream bus mux never switches
// owners back to back.
module rr_arbiter_8_way #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] grant_id,
    output logic       forced
);

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_OWNED   = 1'b1;
    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    logic [0:0]       state_r;
    logic [2:0]       ptr_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [7:0]       grant_r;
    logic             grant_valid_r;
    logic [2:0]       grant_id_r;
    logic             forced_r;

    logic             any_req_s;
    logic             win_found_s;
    logic [2:0]       win_id_s;
    logic [2:0]       cand_s;
    logic             rel_done_s;
    logic             rel_drop_s;
    logic             rel_time_s;
    logic             release_s;
    logic             timeout_only_s;

    assign any_req_s = |req;

    // Rotating priority scan: first requester at or after ptr, wrapping mod 8.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 3'd0;
        cand_s      = ptr_r;
        for (int k = 0; k < 8; k++) begin
            cand_s = ptr_r + 3'(k);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Release causes for the current owner; done and a dropped request take
    // precedence over the timeout when deciding whether to flag a forced end.
    always_comb begin
        rel_done_s     = done;
        rel_drop_s     = ~req[grant_id_r];
        rel_time_s     = (hold_cnt_r == HOLD_MAX_C);
        release_s      = rel_done_s | rel_drop_s | rel_time_s;
        timeout_only_s = rel_time_s & ~rel_done_s & ~rel_drop_s;
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 3'd0;
            hold_cnt_r    <= CNT_ZERO;
            grant_r       <= 8'h00;
            grant_valid_r <= 1'b0;
            grant_id_r    <= 3'd0;
            forced_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    forced_r <= 1'b0;
                    if (any_req_s && win_found_s) begin
                        grant_r       <= 8'h01 << win_id_s;
                        grant_id_r    <= win_id_s;
                        grant_valid_r <= 1'b1;
                        hold_cnt_r    <= CNT_ONE;
                        state_r       <= ST_OWNED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (release_s) begin
                        grant_r       <= 8'h00;
                        grant_valid_r <= 1'b0;
                        ptr_r         <= grant_id_r + 3'd1;
                        hold_cnt_r    <= CNT_ZERO;
                        forced_r      <= timeout_only_s;
                        state_r       <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_ONE;
                        forced_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    ptr_r         <= 3'd0;
                    hold_cnt_r    <= CNT_ZERO;
                    grant_r       <= 8'h00;
                    grant_valid_r <= 1'b0;
                    grant_id_r    <= 3'd0;
                    forced_r      <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign forced      = forced_r;

endmodule

// File: tb/tb_rr_arbiter_8_way.sv
// Directed self-checking bench for rr_arbiter_8_way, plus a small checker
// module holding the grant invariants as assertions.
module rr_arbiter_8_way_chk (
    input logic       clk,
    input logic       reset,
    input logic [7:0] grant,
    input logic       grant_valid,
    input logic [2:0] grant_id
);
    // Grant invariants, sampled on the falling edge away from state updates.
    always @(negedge clk) begin
        if (!reset) begin
            assert ((grant & (grant - 8'd1)) == 8'd0) else $error("grant not one-hot: %h", grant);
            assert (grant_valid == (|grant)) else $error("grant_valid inconsistent with grant %h", grant);
            assert (grant[grant_id] == grant_valid) else $error("grant_id %0d inconsistent with grant %h", grant_id, grant);
        end
    end
endmodule

module tb_rr_arbiter_8_way;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       forced;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rr_arbiter_8_way #(.HOLD_MAX(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .forced(forced)
    );

    rr_arbiter_8_way_chk chk (
        .clk(clk), .reset(reset), .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [7:0] g, input logic [2:0] id);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_valid"}, 32'(grant_valid), 32'(g != 8'h00));
        if (g != 8'h00) check({tag, "_id"}, 32'(grant_id), 32'(id));
        else            check({tag, "_id_held"}, 32'(grant_id), 32'(id));
    endtask

    logic [7:0] t2_g  [3] = '{8'h04, 8'h20, 8'h04};
    logic [2:0] t2_id [3] = '{3'd2, 3'd5, 3'd2};
    logic [7:0] eg;

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;

        // Reset state and idle with no requests
        do_reset();
        check("rst_outputs", {21'd0, grant, grant_valid, grant_id, forced}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {22'd0, grant, grant_valid, forced}, 32'd0);
        end

        // Two requesters, done three cycles after each grant
        do_reset();
        req = 8'b0010_0100;
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_grant("t2", t2_g[i], t2_id[i]);
            tick();
            tick();
            expect_grant("t2_held", t2_g[i], t2_id[i]);
            done = 1'b1;
            tick();
            done = 1'b0;
            expect_grant("t2_gap", 8'h00, t2_id[i]);
            check("t2_gap_forced", 32'(forced), 32'd0);
            tick();
        end

        // All eight requesting, done one cycle after each grant
        do_reset();
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            eg = 8'h01 << (i % 8);
            expect_grant("t3", eg, 3'(i % 8));
            done = 1'b1;
            tick();
            done = 1'b0;
            expect_grant("t3_gap", 8'h00, 3'(i % 8));
            tick();
        end

        // Lone requester 7 hits the hold limit
        do_reset();
        req = 8'h80;
        tick();
        for (int k = 0; k < 15; k++) begin
            expect_grant("t4_hold", 8'h80, 3'd7);
            check("t4_hold_forced", 32'(forced), 32'd0);
            tick();
        end
        expect_grant("t4_timeout", 8'h00, 3'd7);
        check("t4_forced_pulse", 32'(forced), 32'd1);
        tick();
        expect_grant("t4_regrant", 8'h80, 3'd7);
        check("t4_forced_clear", 32'(forced), 32'd0);
        // Pointer wrapped to 0: requester 0 now beats requester 7
        req  = 8'h81;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t4_rel_forced", 32'(forced), 32'd0);
        tick();
        expect_grant("t4_wrap", 8'h01, 3'd0);
        // done and timeout on the same edge: no forced pulse
        req = 8'h01;
        for (int k = 0; k < 14; k++) tick();
        expect_grant("t4_at_limit", 8'h01, 3'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("t4_done_wins", 8'h00, 3'd0);
        check("t4_done_wins_forced", 32'(forced), 32'd0);

        // Grantee 3 drops its request
        do_reset();
        req = 8'h0A;
        tick();
        expect_grant("t5_first", 8'h02, 3'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        expect_grant("t5_owner3", 8'h08, 3'd3);
        req = 8'h02;
        tick();
        expect_grant("t5_drop", 8'h00, 3'd3);
        check("t5_drop_forced", 32'(forced), 32'd0);
        tick();
        expect_grant("t5_next", 8'h02, 3'd1);

        // Reset wins over done and timeout together
        do_reset();
        req = 8'h80;
        tick();
        for (int k = 0; k < 14; k++) tick();
        expect_grant("t6_at_limit", 8'h80, 3'd7);
        done  = 1'b1;
        reset = 1'b1;
        tick();
        check("t6_reset", {21'd0, grant, grant_valid, grant_id, forced}, 32'd0);
        reset = 1'b0;
        done  = 1'b0;

        // Random req/done traffic, invariants every cycle
        for (int i = 0; i < 200; i++) begin
            req  = 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            tick();
            check("rnd_onehot", 32'(grant & (grant - 8'd1)), 32'd0);
            check("rnd_valid", 32'(grant_valid), 32'(|grant));
            check("rnd_id", 32'(grant[grant_id]), 32'(grant_valid));
            if (forced) check("rnd_forced_idle", 32'(grant_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
